vencode_subcarrier: RTL

Colour-subcarrier generator for the composite video encoder. A 32-bit phase accumulator (NCO) produces the 8-bit phase word consumed by `vencode_sin_cos`. It gates the colour-burst window once per line and applies the NTSC/PAL burst phase offsets. It also tracks the PAL V-switch so the downstream chroma modulator can invert V on alternate lines.

---
 rtl/vencode_pkg.sv | 15 +
 rtl/vencode_burst_gate.sv | 67 ++++++
 rtl/vencode_subcarrier.sv | 95 +++++++++
 3 files changed

// File: rtl/vencode_pkg.sv
// Shared constants and types for the composite video encoder.
// Holds the burst phase offsets and the burst-gate FSM state encoding.
package vencode_pkg;

  localparam logic [7:0] BURST_OFS_NTSC    = 8'h80;
  localparam logic [7:0] BURST_OFS_PAL_SW  = 8'h60;
  localparam logic [7:0] BURST_OFS_PAL_NSW = 8'hA0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } burst_state_e;

endpackage

// File: rtl/vencode_burst_gate.sv
// Colour-burst window timer: counts from hsync_start to the burst and across it.
// burst_next is the combinational "next state is BURST" used by the output registers.
module vencode_burst_gate
  import vencode_pkg::*;
#(
  parameter int unsigned BURST_START = 157,
  parameter int unsigned BURST_LEN   = 63
) (
  input  logic clk,
  input  logic rst,
  input  logic hsync_start,
  input  logic burst_inhibit,
  output logic burst_next
);

  localparam logic [8:0] START_LAST = 9'(BURST_START - 1);
  localparam logic [8:0] LEN_LAST   = 9'(BURST_LEN - 1);

  burst_state_e state_q, state_d;
  logic [8:0]   cnt_q, cnt_d;

  // hsync_start restarts (or cancels) the window from any state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (hsync_start) begin
      state_d = burst_inhibit ? IDLE : WAIT;
      cnt_d   = 9'd0;
    end else begin
      case (state_q)
        WAIT: begin
          if (cnt_q == START_LAST) begin
            state_d = BURST;
            cnt_d   = 9'd0;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
        BURST: begin
          if (cnt_q == LEN_LAST) begin
            state_d = IDLE;
            cnt_d   = 9'd0;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 9'd0;
        end
      endcase
    end
  end

  assign burst_next = (state_d == BURST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 9'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/vencode_subcarrier.sv
// Colour-subcarrier NCO with burst gating, NTSC/PAL burst phase offsets and PAL V-switch.
// phase/burst/vswitch are aligned; burst_d/vswitch_d line up with the negedge sin/cos ROM output.
module vencode_subcarrier
  import vencode_pkg::*;
#(
  parameter int unsigned BURST_START = 157,
  parameter int unsigned BURST_LEN   = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pal_mode,
  input  logic [31:0] freq_inc,
  input  logic        hsync_start,
  input  logic        vsync_start,
  input  logic        burst_inhibit,
  output logic [7:0]  phase,
  output logic        burst,
  output logic        vswitch,
  output logic        burst_d,
  output logic        vswitch_d
);

  logic        burst_next;
  logic [31:0] acc_q, acc_d;
  logic [7:0]  phase_q, phase_d;
  logic [7:0]  ofs;
  logic        burst_q;
  logic        vsw_q, vsw_d;
  logic        burst_dly_q, vsw_dly_q;

  vencode_burst_gate #(
    .BURST_START (BURST_START),
    .BURST_LEN   (BURST_LEN)
  ) u_burst_gate (
    .clk           (clk),
    .rst           (rst),
    .hsync_start   (hsync_start),
    .burst_inhibit (burst_inhibit),
    .burst_next    (burst_next)
  );

  // vsync restarts the frame at phase 0 and clears the V-switch, overriding a same-cycle toggle
  always_comb begin
    if (vsync_start) begin
      acc_d = freq_inc;
    end else begin
      acc_d = acc_q + freq_inc;
    end

    if (vsync_start || !pal_mode) begin
      vsw_d = 1'b0;
    end else if (hsync_start) begin
      vsw_d = ~vsw_q;
    end else begin
      vsw_d = vsw_q;
    end

    if (!burst_next) begin
      ofs = 8'h00;
    end else if (!pal_mode) begin
      ofs = BURST_OFS_NTSC;
    end else if (vsw_d) begin
      ofs = BURST_OFS_PAL_SW;
    end else begin
      ofs = BURST_OFS_PAL_NSW;
    end

    phase_d = acc_d[31:24] + ofs;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= 32'd0;
      phase_q     <= 8'd0;
      burst_q     <= 1'b0;
      vsw_q       <= 1'b0;
      burst_dly_q <= 1'b0;
      vsw_dly_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      phase_q     <= phase_d;
      burst_q     <= burst_next;
      vsw_q       <= vsw_d;
      burst_dly_q <= burst_q;
      vsw_dly_q   <= vsw_q;
    end
  end

  assign phase     = phase_q;
  assign burst     = burst_q;
  assign vswitch   = vsw_q;
  assign burst_d   = burst_dly_q;
  assign vswitch_d = vsw_dly_q;

endmodule
